// File: rtl/clk_cal_pkg.sv
// Shared constants for the clock/calendar setting controller: field encoding, strobe map, defaults.
// Pure definitions, no logic; auto-repeat option is SET_CTRL_AUTOREPEAT_EN (used by btn_repeat).
package clk_cal_pkg;

    localparam int HOLD_CYC_DEF   = 50_000_000;
    localparam int REPEAT_CYC_DEF = 10_000_000;
    localparam int TIMEOUT_S_DEF  = 10;

    localparam int FLD_W = 3;
    localparam logic [FLD_W-1:0] FLD_RUN     = 3'd0;
    localparam logic [FLD_W-1:0] FLD_HOUR    = 3'd1;
    localparam logic [FLD_W-1:0] FLD_MIN     = 3'd2;
    localparam logic [FLD_W-1:0] FLD_MONTH   = 3'd3;
    localparam logic [FLD_W-1:0] FLD_DAY     = 3'd4;
    localparam logic [FLD_W-1:0] FLD_YEAR    = 3'd5;
    localparam logic [FLD_W-1:0] FLD_CENTURY = 3'd6;

    typedef enum logic [FLD_W-1:0] {
        ST_RUN     = FLD_RUN,
        ST_HOUR    = FLD_HOUR,
        ST_MIN     = FLD_MIN,
        ST_MONTH   = FLD_MONTH,
        ST_DAY     = FLD_DAY,
        ST_YEAR    = FLD_YEAR,
        ST_CENTURY = FLD_CENTURY
    } field_e;

    // Bit positions inside the packed strobe vector.
    localparam int STB_W       = 6;
    localparam int STB_HOUR    = 0;
    localparam int STB_MINUTE  = 1;
    localparam int STB_MONTH   = 2;
    localparam int STB_DAY     = 3;
    localparam int STB_YEAR    = 4;
    localparam int STB_CENTURY = 5;

    function automatic logic [STB_W-1:0] field_strobe(field_e f);
        logic [STB_W-1:0] s;
        s = '0;
        case (f)
            ST_HOUR:    s[STB_HOUR]    = 1'b1;
            ST_MIN:     s[STB_MINUTE]  = 1'b1;
            ST_MONTH:   s[STB_MONTH]   = 1'b1;
            ST_DAY:     s[STB_DAY]     = 1'b1;
            ST_YEAR:    s[STB_YEAR]    = 1'b1;
            ST_CENTURY: s[STB_CENTURY] = 1'b1;
            default:    s = '0;
        endcase
        return s;
    endfunction

    function automatic field_e next_field(field_e f);
        field_e n;
        case (f)
            ST_RUN:   n = ST_HOUR;
            ST_HOUR:  n = ST_MIN;
            ST_MIN:   n = ST_MONTH;
            ST_MONTH: n = ST_DAY;
            ST_DAY:   n = ST_YEAR;
            ST_YEAR:  n = ST_CENTURY;
            default:  n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/clk_cal_set_ctrl_if.sv
// User-side bundle of the setting controller: buttons and 1 Hz tick in, strobes and display state out.
// slave = controller, master = button/display side.
interface clk_cal_set_ctrl_if;
    import clk_cal_pkg::*;

    logic             tick_1Hz;
    logic             btn_mode;
    logic             btn_inc;
    logic             inc_hour;
    logic             inc_minute;
    logic             inc_month;
    logic             inc_day;
    logic             inc_year;
    logic             inc_century;
    logic [FLD_W-1:0] field_sel;
    logic             set_active;
    logic             blink_on;

    modport slave (
        input  tick_1Hz, btn_mode, btn_inc,
        output inc_hour, inc_minute, inc_month, inc_day, inc_year, inc_century,
        output field_sel, set_active, blink_on
    );

    modport master (
        output tick_1Hz, btn_mode, btn_inc,
        input  inc_hour, inc_minute, inc_month, inc_day, inc_year, inc_century,
        input  field_sel, set_active, blink_on
    );

endinterface

// File: rtl/clk_cal_set_ctrl_btn_repeat.sv
// btn_repeat: rising-edge detect with re-arm, plus hold/repeat press generation (combinational press_o).
// No backpressure; repeat counter exists only with SET_CTRL_AUTOREPEAT_EN defined.
module btn_repeat #(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    input  logic rearm_i,
    output logic press_o
);

    if (HOLD_CYC < 1 || REPEAT_CYC < 1 || REPEAT_CYC > HOLD_CYC) begin : g_param_chk
        $error("btn_repeat: need 1 <= REPEAT_CYC <= HOLD_CYC");
    end

    logic btn_q;
    logic edge_w;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) btn_q <= 1'b0;
        else          btn_q <= btn_i;
    end

    // A rising edge coinciding with a state change belongs to the old field: drop it.
    assign edge_w = btn_i & ~btn_q & ~rearm_i;

`ifdef SET_CTRL_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_w;
    logic             act_q, act_d;
    logic             rep_q, rep_d;
    logic             fire_w;

    always_comb begin
        cnt_d    = cnt_q;
        act_d    = act_q;
        rep_d    = rep_q;
        fire_w   = 1'b0;
        target_w = rep_q ? CNT_W'(REPEAT_CYC) : CNT_W'(HOLD_CYC);
        if (rearm_i || !btn_i) begin
            act_d = 1'b0;
            rep_d = 1'b0;
            cnt_d = '0;
        end else if (edge_w) begin
            act_d = 1'b1;
            rep_d = 1'b0;
            cnt_d = CNT_W'(1);
        end else if (act_q) begin
            // cnt_q counts cycles since the last press, so it never exceeds the target.
            if (cnt_q == target_w) begin
                fire_w = 1'b1;
                rep_d  = 1'b1;
                cnt_d  = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            act_q <= 1'b0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            rep_q <= rep_d;
        end
    end

    assign press_o = edge_w | fire_w;
`else
    assign press_o = edge_w;
`endif

endmodule

// File: rtl/clk_cal_set_ctrl.sv
// clk_cal_set_ctrl: mode/inc buttons -> field select FSM and registered 1-cycle increment strobes (1-cycle latency).
// No backpressure; auto-repeat of held inc built only with SET_CTRL_AUTOREPEAT_EN defined.
module clk_cal_set_ctrl
    import clk_cal_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF,
    parameter int TIMEOUT_S  = TIMEOUT_S_DEF
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    clk_cal_set_ctrl_if.slave   sif
);

    localparam int TO_W = $clog2(TIMEOUT_S + 1);

    field_e           state_q, state_d;
    logic             mode_q;
    logic [TO_W-1:0]  to_q, to_d;
    logic             blink_q, blink_d;
    logic             set_q, set_d;
    logic [STB_W-1:0] stb_q, stb_d;

    logic mode_edge, timeout, rearm, press, fire;

    assign mode_edge = sif.btn_mode & ~mode_q;
    // Timeout is judged on the pre-clear count so it beats a simultaneous mode edge.
    assign timeout   = (state_q != ST_RUN) && sif.tick_1Hz && (to_q == TO_W'(TIMEOUT_S - 1));
    assign rearm     = (state_d != state_q);

    btn_repeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_inc_btn (
        .clk_i   (clk_100MHz),
        .rst_n_i (reset_n),
        .btn_i   (sif.btn_inc),
        .rearm_i (rearm),
        .press_o (press)
    );

    assign fire = press & (state_q != ST_RUN) & ~rearm;

    always_comb begin
        state_d = state_q;
        if (timeout)        state_d = ST_RUN;
        else if (mode_edge) state_d = next_field(state_q);
    end

    always_comb begin
        stb_d   = fire ? field_strobe(state_q) : '0;
        set_d   = (state_d != ST_RUN);
        to_d    = to_q;
        blink_d = blink_q;
        if (state_d == ST_RUN || mode_edge || fire) to_d = '0;
        else if (sif.tick_1Hz)                      to_d = to_q + 1'b1;
        if (state_d == ST_RUN || rearm || fire) blink_d = 1'b1;
        else if (sif.tick_1Hz)                  blink_d = ~blink_q;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            mode_q  <= 1'b0;
            to_q    <= '0;
            blink_q <= 1'b1;
            set_q   <= 1'b0;
            stb_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= sif.btn_mode;
            to_q    <= to_d;
            blink_q <= blink_d;
            set_q   <= set_d;
            stb_q   <= stb_d;
        end
    end

    assign sif.field_sel   = state_q;
    assign sif.set_active  = set_q;
    assign sif.blink_on    = blink_q;
    assign sif.inc_hour    = stb_q[STB_HOUR];
    assign sif.inc_minute  = stb_q[STB_MINUTE];
    assign sif.inc_month   = stb_q[STB_MONTH];
    assign sif.inc_day     = stb_q[STB_DAY];
    assign sif.inc_year    = stb_q[STB_YEAR];
    assign sif.inc_century = stb_q[STB_CENTURY];

endmodule

// File: tb/tb_clk_cal_set_ctrl.sv
// Bench for clk_cal_set_ctrl: vector table, directed corner sequences, then random traffic against a model.
module tb_clk_cal_set_ctrl;

    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int TMO  = 3;
`ifdef SET_CTRL_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_cal_set_ctrl_if sif();

    clk_cal_set_ctrl #(
        .HOLD_CYC   (HOLD),
        .REPEAT_CYC (REP),
        .TIMEOUT_S  (TMO)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .sif        (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: field number, button history, cycles since inc edge (-1 = not tracking).
    int         m_fld;
    bit         m_pm, m_pi;
    int         m_hold;
    int         m_idle;
    bit         m_blink;
    logic [5:0] m_stb;

    typedef struct {
        bit         m;
        bit         i;
        bit         t;
        int         fld;
        logic [5:0] stb;
        bit         blink;
    } vec_t;
    vec_t tbl[23];

    function automatic logic [10:0] pack_dut();
        return {sif.field_sel, sif.set_active, sif.blink_on, sif.inc_century, sif.inc_year,
                sif.inc_day, sif.inc_month, sif.inc_minute, sif.inc_hour};
    endfunction

    function automatic logic [10:0] exp_vec(int fld, logic [5:0] stb, bit blink);
        return {3'(fld), (fld != 0), blink, stb};
    endfunction

    task automatic check(string name, logic [10:0] got, logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got fld=%0d set=%b blink=%b stb=%b, want fld=%0d set=%b blink=%b stb=%b",
                     name, got[10:8], got[7], got[6], got[5:0], exp[10:8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic check_val(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fld = 0; m_pm = 0; m_pi = 0; m_hold = -1; m_idle = 0; m_blink = 1; m_stb = '0;
    endtask

    task automatic model_step(bit md, bit in, bit tk);
        bit medge, iedge, to, chg, fire;
        int nf;
        medge = md && !m_pm;
        iedge = in && !m_pi;
        to    = (m_fld != 0) && tk && (m_idle == TMO - 1);
        nf    = to ? 0 : (medge ? (m_fld + 1) % 7 : m_fld);
        chg   = (nf != m_fld);
        fire  = 1'b0;
        if (!in || chg) m_hold = -1;
        else if (iedge) begin
            m_hold = 0;
            fire   = (m_fld != 0);
        end else if (m_hold >= 0) begin
            m_hold++;
            if (AUTOREP && m_hold >= HOLD && (m_hold - HOLD) % REP == 0) fire = (m_fld != 0);
        end
        m_stb = '0;
        if (fire) m_stb[m_fld - 1] = 1'b1;
        if (nf == 0 || medge || fire) m_idle = 0;
        else if (tk) m_idle++;
        if (nf == 0 || chg || fire) m_blink = 1'b1;
        else if (tk) m_blink = !m_blink;
        m_fld = nf; m_pm = md; m_pi = in;
    endtask

    task automatic cyc(bit md, bit in, bit tk, string name);
        sif.btn_mode = md; sif.btn_inc = in; sif.tick_1Hz = tk;
        model_step(md, in, tk);
        @(posedge clk); #1;
        check(name, pack_dut(), exp_vec(m_fld, m_stb, m_blink));
    endtask

    task automatic do_reset();
        sif.btn_mode = 0; sif.btn_inc = 0; sif.tick_1Hz = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", pack_dut(), exp_vec(0, 6'h00, 1'b1));
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic mode_edge(string name);
        cyc(1, 0, 0, name);
        cyc(0, 0, 0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] got_mask, exp_mask;
        int cnt_tgt, cnt_other;
        bit md, in, tk;

        // {mode, inc, tick} -> {field_sel, strobes, blink_on} one cycle later
        tbl[0]  = '{0, 0, 0, 0, 6'h00, 1};
        tbl[1]  = '{1, 0, 0, 1, 6'h00, 1};
        tbl[2]  = '{0, 0, 0, 1, 6'h00, 1};
        tbl[3]  = '{1, 0, 0, 2, 6'h00, 1};
        tbl[4]  = '{0, 0, 0, 2, 6'h00, 1};
        tbl[5]  = '{0, 1, 0, 2, 6'h02, 1};
        tbl[6]  = '{0, 0, 0, 2, 6'h00, 1};
        tbl[7]  = '{0, 0, 1, 2, 6'h00, 0};
        tbl[8]  = '{0, 1, 0, 2, 6'h02, 1};
        tbl[9]  = '{0, 1, 1, 2, 6'h00, 0};
        tbl[10] = '{1, 0, 0, 3, 6'h00, 1};
        tbl[11] = '{0, 1, 0, 3, 6'h04, 1};
        tbl[12] = '{1, 1, 0, 4, 6'h00, 1};
        tbl[13] = '{0, 0, 0, 4, 6'h00, 1};
        tbl[14] = '{1, 1, 0, 5, 6'h00, 1};
        tbl[15] = '{0, 1, 0, 5, 6'h00, 1};
        tbl[16] = '{0, 0, 0, 5, 6'h00, 1};
        tbl[17] = '{0, 1, 0, 5, 6'h10, 1};
        tbl[18] = '{0, 0, 1, 5, 6'h00, 0};
        tbl[19] = '{0, 0, 1, 5, 6'h00, 1};
        tbl[20] = '{0, 0, 1, 0, 6'h00, 1};
        tbl[21] = '{0, 1, 0, 0, 6'h00, 1};
        tbl[22] = '{0, 0, 0, 0, 6'h00, 1};

        do_reset();
        for (int k = 0; k < 23; k++) begin
            sif.btn_mode = tbl[k].m; sif.btn_inc = tbl[k].i; sif.tick_1Hz = tbl[k].t;
            @(posedge clk); #1;
            check($sformatf("vec%0d", k), pack_dut(), exp_vec(tbl[k].fld, tbl[k].stb, tbl[k].blink));
        end

        // Field walk with presses in MIN and in RUN.
        do_reset();
        mode_edge("walk");
        mode_edge("walk");
        check_val("walk_min", 64'(sif.field_sel), 64'd2);
        cnt_tgt = 0; cnt_other = 0;
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1, 0, "min_press");
            cnt_tgt += int'(sif.inc_minute);
            cnt_other += int'(sif.inc_hour) + int'(sif.inc_month) + int'(sif.inc_day)
                       + int'(sif.inc_year) + int'(sif.inc_century);
            for (int q = 0; q < 2; q++) begin
                cyc(0, 0, 0, "min_gap");
                cnt_tgt += int'(sif.inc_minute);
            end
        end
        check_val("min_strobes", 64'(cnt_tgt), 64'd3);
        check_val("min_other", 64'(cnt_other), 64'd0);
        for (int e = 3; e <= 7; e++) begin
            mode_edge("walk");
            check_val($sformatf("walk_edge%0d", e), 64'(sif.field_sel), 64'(e % 7));
        end
        cnt_other = 0;
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1, 0, "run_press");
            cnt_other += int'(pack_dut() & 11'h03f) != 0 ? 1 : 0;
            cyc(0, 0, 0, "run_gap");
        end
        check_val("run_strobes", 64'(cnt_other), 64'd0);

        // 41-cycle hold in DAY: record strobe offsets relative to the inc edge.
        for (int e = 0; e < 4; e++) mode_edge("to_day");
        got_mask = '0;
        for (int j = 0; j < 46; j++) begin
            cyc(0, (j < 41), 0, "hold_day");
            if (sif.inc_day) got_mask[j + 1] = 1'b1;
        end
        exp_mask = '0;
        exp_mask[1] = 1'b1;
        if (AUTOREP) for (int o = 1 + HOLD; o <= 41; o += REP) exp_mask[o] = 1'b1;
        check_val("repeat_mask", got_mask, exp_mask);

        // Inactivity timeout in YEAR, restarted by a press after the 2nd tick.
        do_reset();
        for (int e = 0; e < 5; e++) mode_edge("to_year");
        cyc(0, 0, 1, "to_tick1");
        repeat (3) cyc(0, 0, 0, "to_gap");
        cyc(0, 0, 1, "to_tick2");
        cyc(0, 1, 0, "to_press");
        cyc(0, 0, 0, "to_gap");
        cyc(0, 0, 1, "to_tick3");
        check_val("to_restart", 64'(sif.field_sel), 64'd5);
        cyc(0, 0, 0, "to_gap");
        cyc(0, 0, 1, "to_tick4");
        check_val("to_before", 64'(sif.field_sel), 64'd5);
        cyc(0, 0, 1, "to_tick5");
        check_val("to_expire", 64'(sif.field_sel), 64'd0);

        // Reset in the middle of a hold in CENTURY.
        do_reset();
        for (int e = 0; e < 6; e++) mode_edge("to_cent");
        for (int j = 0; j < 9; j++) cyc(0, 1, 0, "cent_hold");
        #3;
        rst_n = 1'b0;
        sif.btn_inc = 1'b0;
        #1;
        check("async_reset", pack_dut(), exp_vec(0, 6'h00, 1'b1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        cnt_other = 0;
        for (int j = 0; j < 30; j++) begin
            cyc(0, 0, 0, "post_reset");
            cnt_other += int'(pack_dut() & 11'h03f) != 0 ? 1 : 0;
        end
        check_val("post_reset_strobes", 64'(cnt_other), 64'd0);

        // Random traffic against the model.
        do_reset();
        md = 0; in = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) md = !md;
            if ($urandom_range(in ? 60 : 10) == 0) in = !in;
            tk = ($urandom_range(9) == 0);
            cyc(md, in, tk, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
